// File: rtl/serpent_inv_sbox_keymix.sv
// Serpent decryption round stage: column-wise inverse S-box plus subkey XOR,
// registered behind a valid/ready handshake with an optional 2-entry skid buffer.
module serpent_inv_sbox_keymix #(
  parameter bit KEY_XOR = 1'b1,
  parameter bit SKID    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_round,
  input  logic [31:0] i_word_0,
  input  logic [31:0] i_word_1,
  input  logic [31:0] i_word_2,
  input  logic [31:0] i_word_3,
  input  logic [31:0] i_key_0,
  input  logic [31:0] i_key_1,
  input  logic [31:0] i_key_2,
  input  logic [31:0] i_key_3,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [4:0]  o_round,
  output logic [31:0] o_word_0,
  output logic [31:0] o_word_1,
  output logic [31:0] o_word_2,
  output logic [31:0] o_word_3
);

  // state   | meaning
  // S_EMPTY | nothing held, output invalid
  // S_ONE   | main register holds a result
  // S_TWO   | main and skid both hold results, upstream stalled
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  localparam logic [3:0] INV_SBOX [8][16] = '{
    '{4'd13, 4'd3,  4'd11, 4'd0,  4'd10, 4'd6,  4'd5,  4'd12, 4'd1,  4'd14, 4'd4,  4'd7,  4'd15, 4'd9,  4'd8,  4'd2},
    '{4'd5,  4'd8,  4'd2,  4'd14, 4'd15, 4'd6,  4'd12, 4'd3,  4'd11, 4'd4,  4'd7,  4'd9,  4'd1,  4'd13, 4'd10, 4'd0},
    '{4'd12, 4'd9,  4'd15, 4'd4,  4'd11, 4'd14, 4'd1,  4'd2,  4'd0,  4'd3,  4'd6,  4'd13, 4'd5,  4'd8,  4'd10, 4'd7},
    '{4'd0,  4'd9,  4'd10, 4'd7,  4'd11, 4'd14, 4'd6,  4'd13, 4'd3,  4'd5,  4'd12, 4'd2,  4'd4,  4'd8,  4'd15, 4'd1},
    '{4'd5,  4'd0,  4'd8,  4'd3,  4'd10, 4'd9,  4'd7,  4'd14, 4'd2,  4'd12, 4'd11, 4'd6,  4'd4,  4'd15, 4'd13, 4'd1},
    '{4'd8,  4'd15, 4'd2,  4'd9,  4'd4,  4'd1,  4'd13, 4'd14, 4'd11, 4'd6,  4'd5,  4'd3,  4'd7,  4'd12, 4'd10, 4'd0},
    '{4'd15, 4'd10, 4'd1,  4'd13, 4'd5,  4'd3,  4'd6,  4'd0,  4'd4,  4'd9,  4'd14, 4'd7,  4'd2,  4'd12, 4'd8,  4'd11},
    '{4'd3,  4'd0,  4'd6,  4'd13, 4'd9,  4'd14, 4'd15, 4'd8,  4'd5,  4'd12, 4'd11, 4'd7,  4'd10, 4'd1,  4'd4,  4'd2}
  };

  logic [3:0][31:0] w_sbox;
  logic [3:0][31:0] w_key;
  logic [132:0]     w_in;
  logic [132:0]     r_main;
  logic [132:0]     r_skid;
  state_t           r_state;
  state_t           w_next;
  logic             r_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  always_comb begin
    logic [3:0] v_nib;
    logic [3:0] v_sub;
    w_sbox = '0;
    for (int j = 0; j < 32; j++) begin
      v_nib = {i_word_3[j], i_word_2[j], i_word_1[j], i_word_0[j]};
      v_sub = INV_SBOX[i_round[2:0]][v_nib];
      for (int n = 0; n < 4; n++) w_sbox[n][j] = v_sub[n];
    end
  end

  assign w_key = KEY_XOR ? {i_key_3, i_key_2, i_key_1, i_key_0} : '0;
  assign w_in  = {i_round, w_sbox ^ w_key};

  assign o_valid  = (r_state != S_EMPTY);
  assign w_accept = i_valid & o_ready;
  assign w_drain  = o_valid & i_ready;

  generate
    if (SKID) begin : g_skid
      assign o_ready = r_ready;
    end else begin : g_single
      assign o_ready = ~o_valid | i_ready;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != S_TWO);
    end
  end

  // Without the skid, o_ready in S_ONE implies a drain, so S_TWO is unreachable.
  always_comb begin
    w_next         = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_next      = S_ONE;
          w_load_main = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_next      = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_drain) begin
          w_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_drain) begin
          w_next         = S_ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main)         r_main <= w_in;
      else if (w_skid_to_main) r_main <= r_skid;
      if (w_load_skid)         r_skid <= w_in;
    end
  end

  assign o_round  = r_main[132:128];
  assign o_word_0 = r_main[31:0];
  assign o_word_1 = r_main[63:32];
  assign o_word_2 = r_main[95:64];
  assign o_word_3 = r_main[127:96];

endmodule

// File: tb/tb_serpent_inv_sbox_keymix.sv
// Bench for serpent_inv_sbox_keymix: directed vector table, handshake corner
// sequences and a randomized stream against a table-lookup reference model.
module tb_serpent_inv_sbox_keymix;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [4:0]  i_round = '0;
  logic [31:0] i_word_0 = '0, i_word_1 = '0, i_word_2 = '0, i_word_3 = '0;
  logic [31:0] i_key_0 = '0, i_key_1 = '0, i_key_2 = '0, i_key_3 = '0;
  logic        o_ready, o_valid;
  logic [4:0]  o_round;
  logic [31:0] o_word_0, o_word_1, o_word_2, o_word_3;
  logic        nk_ready, nk_valid;
  logic [4:0]  nk_round;
  logic [31:0] nk_word_0, nk_word_1, nk_word_2, nk_word_3;

  always #5 i_clk = ~i_clk;

  serpent_inv_sbox_keymix #(.KEY_XOR(1'b1), .SKID(1'b1)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_round(i_round), .i_word_0(i_word_0), .i_word_1(i_word_1),
    .i_word_2(i_word_2), .i_word_3(i_word_3), .i_key_0(i_key_0),
    .i_key_1(i_key_1), .i_key_2(i_key_2), .i_key_3(i_key_3),
    .o_valid(o_valid), .i_ready(i_ready), .o_round(o_round),
    .o_word_0(o_word_0), .o_word_1(o_word_1), .o_word_2(o_word_2), .o_word_3(o_word_3));

  serpent_inv_sbox_keymix #(.KEY_XOR(1'b0), .SKID(1'b0)) u_nokey (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(nk_ready),
    .i_round(i_round), .i_word_0(i_word_0), .i_word_1(i_word_1),
    .i_word_2(i_word_2), .i_word_3(i_word_3), .i_key_0(i_key_0),
    .i_key_1(i_key_1), .i_key_2(i_key_2), .i_key_3(i_key_3),
    .o_valid(nk_valid), .i_ready(i_ready), .o_round(nk_round),
    .o_word_0(nk_word_0), .o_word_1(nk_word_1), .o_word_2(nk_word_2), .o_word_3(nk_word_3));

  wire [127:0] o_w  = {o_word_3, o_word_2, o_word_1, o_word_0};
  wire [127:0] nk_w = {nk_word_3, nk_word_2, nk_word_1, nk_word_0};

  int checks = 0;
  int errors = 0;

  int INV [8][16] = '{
    '{13, 3, 11, 0, 10, 6, 5, 12, 1, 14, 4, 7, 15, 9, 8, 2},
    '{5, 8, 2, 14, 15, 6, 12, 3, 11, 4, 7, 9, 1, 13, 10, 0},
    '{12, 9, 15, 4, 11, 14, 1, 2, 0, 3, 6, 13, 5, 8, 10, 7},
    '{0, 9, 10, 7, 11, 14, 6, 13, 3, 5, 12, 2, 4, 8, 15, 1},
    '{5, 0, 8, 3, 10, 9, 7, 14, 2, 12, 11, 6, 4, 15, 13, 1},
    '{8, 15, 2, 9, 4, 1, 13, 14, 11, 6, 5, 3, 7, 12, 10, 0},
    '{15, 10, 1, 13, 5, 3, 6, 0, 4, 9, 14, 7, 2, 12, 8, 11},
    '{3, 0, 6, 13, 9, 14, 15, 8, 5, 12, 11, 7, 10, 1, 4, 2}
  };

  function automatic logic [127:0] model(input logic [4:0] rnd, input logic [127:0] w,
                                         input logic [127:0] k, input bit kx);
    logic [127:0] r = '0;
    int n, m;
    for (int j = 0; j < 32; j++) begin
      n = 0;
      for (int b = 0; b < 4; b++) if (w[32*b+j]) n = n + (1 << b);
      m = INV[int'(rnd) % 8][n];
      for (int b = 0; b < 4; b++) r[32*b+j] = ((m >> b) & 1) == 1;
    end
    if (kx) r = r ^ k;
    return r;
  endfunction

  task automatic chk(input string name, input logic [132:0] act, input logic [132:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rnd, input logic [127:0] w, input logic [127:0] k);
    i_round = rnd;
    {i_word_3, i_word_2, i_word_1, i_word_0} = w;
    {i_key_3, i_key_2, i_key_1, i_key_0} = k;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct packed {
    logic [4:0]   rnd;
    logic [127:0] w;
    logic [127:0] k;
    logic [127:0] exp;
  } vec_t;

  localparam logic [31:0] F = 32'hFFFF_FFFF;
  localparam logic [31:0] Z = 32'h0;

  // Scoreboard-driven streaming state.
  logic [132:0] sb_q[$];
  logic [132:0] held;
  bit           held_chk = 0;
  bit           pend = 0;
  int           cyc = 0;
  int           pops = 0;
  int           first_pop = -1;
  int           last_pop = -1;
  logic [4:0]   d_rnd;
  logic [127:0] d_w, d_k;

  task automatic do_cycle(input bit want_v, input bit rdy);
    logic [132:0] exp;
    if (!pend && want_v) begin
      d_rnd = 5'($urandom_range(0, 31));
      d_w = {$urandom, $urandom, $urandom, $urandom};
      d_k = {$urandom, $urandom, $urandom, $urandom};
      pend = 1;
    end
    i_valid = pend;
    i_ready = rdy;
    drive(d_rnd, d_w, d_k);
    if (held_chk) chk("hold_stable", {o_valid, o_round, o_w}, {1'b1, held});
    if (o_valid && rdy) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {o_round, o_w}, '0);
      end else begin
        exp = sb_q.pop_front();
        chk("stream_data", {o_round, o_w}, exp);
      end
      pops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    held_chk = o_valid && !rdy;
    held = {o_round, o_w};
    if (pend && o_ready) begin
      sb_q.push_back({d_rnd, model(d_rnd, d_w, d_k, 1'b1)});
      pend = 0;
    end
    tick();
    cyc++;
  endtask

  task automatic drain_all();
    int n = 0;
    while ((sb_q.size() != 0 || o_valid) && n < 40) begin
      do_cycle(1'b0, 1'b1);
      n++;
    end
    chk("drain_timeout", 133'(sb_q.size()), '0);
    chk("drain_empty", {132'(0), o_valid}, '0);
  endtask

  vec_t vecs[6];
  int   s;

  initial begin
    vecs[0] = '{rnd: 5'd0,  w: {Z, Z, Z, Z}, k: '0, exp: {F, F, Z, F}};
    vecs[1] = '{rnd: 5'd7,  w: {F, F, F, F}, k: '0, exp: {Z, Z, F, Z}};
    vecs[2] = '{rnd: 5'd15, w: {F, F, F, F}, k: '0, exp: {Z, Z, F, Z}};
    vecs[3] = '{rnd: 5'd3,  w: {Z, Z, Z, Z}, k: {32'd4, 32'd3, 32'd2, 32'd1},
                exp: {32'd4, 32'd3, 32'd2, 32'd1}};
    vecs[4] = '{rnd: 5'd1,  w: {Z, Z, Z, Z}, k: '0, exp: {Z, F, Z, F}};
    vecs[5] = '{rnd: 5'd4,  w: {F, F, F, F}, k: '0, exp: {Z, Z, Z, F}};

    // Reset state
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();
    chk("reset_valid", {132'(0), o_valid}, '0);
    chk("reset_ready", {132'(0), o_ready}, 133'(1));
    chk("reset_out", {o_round, o_w}, '0);
    chk("reset_nk_ready", {132'(0), nk_ready}, 133'(1));

    // Directed vectors, single beats
    i_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1;
      drive(vecs[i].rnd, vecs[i].w, vecs[i].k);
      tick();
      i_valid = 1'b0;
      chk("vec_valid", {132'(0), o_valid}, 133'(1));
      chk("vec_data", {o_round, o_w}, {vecs[i].rnd, vecs[i].exp});
      chk("vec_nokey", {nk_valid, nk_round, nk_w},
          {1'b1, vecs[i].rnd, model(vecs[i].rnd, vecs[i].w, vecs[i].k, 1'b0)});
      tick();
      chk("vec_drained", {132'(0), o_valid}, '0);
    end

    // 8 back-to-back beats, downstream always ready
    pops = 0; first_pop = -1; s = cyc;
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b1);
    drain_all();
    chk("b2b_count", 133'(pops), 133'(8));
    chk("b2b_latency", 133'(first_pop), 133'(s + 1));
    chk("b2b_consecutive", 133'(last_pop - first_pop), 133'(7));

    // Downstream stall for 4 cycles while upstream keeps pushing
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b0);
    chk("stall_ready_low", {131'(0), o_valid, o_ready}, 133'(2'b10));
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b0);
    chk("stall_still_low", {132'(0), o_ready}, '0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b1);
    drain_all();

    // Randomized stream
    for (int i = 0; i < 400; i++) do_cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    drain_all();

    // Async reset with both entries full
    do_cycle(1'b1, 1'b0);
    do_cycle(1'b1, 1'b0);
    chk("pre_reset_full", {131'(0), o_valid, o_ready}, 133'(2'b10));
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async_reset_valid", {132'(0), o_valid}, '0);
    chk("async_reset_out", {o_round, o_w}, '0);
    i_valid = 1'b0;
    pend = 0;
    held_chk = 0;
    sb_q.delete();
    tick();
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("post_reset_ready", {131'(0), o_valid, o_ready}, 133'(2'b01));
    for (int i = 0; i < 30; i++) do_cycle(1'b1, ($urandom_range(0, 1) != 0));
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
